// File: rtl/enemy_column_array.sv
// enemy_column_array: a column of rows_p invaders sharing one x position.
// Tracks per-row alive state, march/drop motion, shot hit resolution,
// landed / all-dead detection and the column's pixel colour.
//
// Ports
//   clk_i, reset_i          clock, synchronous active-high reset
//   start_i                 begin marching (IDLE -> MARCH)
//   frame_i                 one pulse per video frame, paces the march
//   reverse_i               flip direction and drop one step
//   hit_i, hit_x_i, hit_y_i shot point, valid while hit_i is high
//   pixel_x_i, pixel_y_i    current VGA pixel
//   left_pos_o/right_pos_o  horizontal extent of the column
//   bottom_pos_o            bottom y of the lowest alive row (0 if none)
//   shooter_row_o           index of the lowest alive row (0 if none)
//   hit_ack_o, hit_row_o    registered kill report, one cycle after hit_i
//   alive_o, all_dead_o     alive mask and its all-zero flag
//   landed_o                lowest alive row has reached land_line_p
//   red_o/green_o/blue_o    registered pixel colour

// Per-row geometry: box bounds and the two point-in-box tests.
module enemy_column_row #(
  parameter int         row_idx_p   = 0,
  parameter logic [9:0] top_start_p = 10'd9,
  parameter int         row_pitch_p = 40,
  parameter int         enemy_w_p   = 24,
  parameter int         enemy_h_p   = 16
) (
  input  logic [9:0] left_i,
  input  logic [9:0] y_off_i,
  input  logic       alive_i,
  input  logic [9:0] hit_x_i,
  input  logic [9:0] hit_y_i,
  input  logic [9:0] pix_x_i,
  input  logic [9:0] pix_y_i,
  output logic       hit_match_o,
  output logic       pix_match_o,
  output logic [9:0] bottom_o
);
  logic [9:0] top, right;

  always_comb begin
    top      = top_start_p + y_off_i + 10'(row_idx_p * row_pitch_p);
    bottom_o = top + 10'(enemy_h_p - 1);
    right    = left_i + 10'(enemy_w_p - 1);
    hit_match_o = alive_i &&
                  (hit_x_i >= left_i) && (hit_x_i <= right) &&
                  (hit_y_i >= top)    && (hit_y_i <= bottom_o);
    pix_match_o = alive_i &&
                  (pix_x_i >= left_i) && (pix_x_i <= right) &&
                  (pix_y_i >= top)    && (pix_y_i <= bottom_o);
  end
endmodule

module enemy_column_array #(
  parameter int         rows_p            = 4,
  parameter logic [9:0] left_start_p      = 10'd9,
  parameter logic [9:0] top_start_p       = 10'd9,
  parameter int         row_pitch_p       = 40,
  parameter int         enemy_w_p         = 24,
  parameter int         enemy_h_p         = 16,
  parameter int         step_p            = 4,
  parameter int         drop_p            = 8,
  parameter int         frames_per_step_p = 30,
  parameter logic [9:0] land_line_p       = 10'd440
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              frame_i,
  input  logic              reverse_i,
  input  logic              hit_i,
  input  logic [9:0]        hit_x_i,
  input  logic [9:0]        hit_y_i,
  input  logic [9:0]        pixel_x_i,
  input  logic [9:0]        pixel_y_i,
  output logic [9:0]        left_pos_o,
  output logic [9:0]        right_pos_o,
  output logic [9:0]        bottom_pos_o,
  output logic [2:0]        shooter_row_o,
  output logic              hit_ack_o,
  output logic [2:0]        hit_row_o,
  output logic [rows_p-1:0] alive_o,
  output logic              all_dead_o,
  output logic              landed_o,
  output logic [3:0]        red_o,
  output logic [3:0]        green_o,
  output logic [3:0]        blue_o
);
  localparam int CW = $clog2(frames_per_step_p) + 1;

  typedef enum logic [1:0] {IDLE, MARCH, DEAD, LANDED} state_t;

  state_t            state_q, state_d;
  logic [9:0]        x_q, x_d;
  logic [9:0]        y_off_q, y_off_d;
  logic              dir_left_q, dir_left_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [rows_p-1:0] alive_q, alive_d;
  logic              hit_ack_q, hit_ack_d;
  logic [2:0]        hit_row_q, hit_row_d;
  logic [11:0]       rgb_q, rgb_d;

  logic [rows_p-1:0]       hit_m, pix_m;
  logic [rows_p-1:0][9:0]  row_bottom;

  for (genvar g = 0; g < rows_p; g++) begin : g_row
    enemy_column_row #(
      .row_idx_p  (g),
      .top_start_p(top_start_p),
      .row_pitch_p(row_pitch_p),
      .enemy_w_p  (enemy_w_p),
      .enemy_h_p  (enemy_h_p)
    ) u_row (
      .left_i     (x_q),
      .y_off_i    (y_off_q),
      .alive_i    (alive_q[g]),
      .hit_x_i    (hit_x_i),
      .hit_y_i    (hit_y_i),
      .pix_x_i    (pixel_x_i),
      .pix_y_i    (pixel_y_i),
      .hit_match_o(hit_m[g]),
      .pix_match_o(pix_m[g]),
      .bottom_o   (row_bottom[g])
    );
  end

  function automatic logic [11:0] row_colour(input int idx);
    case (idx)
      0:       row_colour = 12'hF0F;
      1:       row_colour = 12'h0FF;
      2:       row_colour = 12'hFF0;
      default: row_colour = 12'h0F0;
    endcase
  endfunction

  // Lowest alive row = highest set bit of the alive mask.
  always_comb begin
    shooter_row_o = 3'd0;
    bottom_pos_o  = 10'd0;
    for (int i = 0; i < rows_p; i++) begin
      if (alive_q[i]) begin
        shooter_row_o = 3'(i);
        bottom_pos_o  = row_bottom[i];
      end
    end
    all_dead_o = (alive_q == '0);
    landed_o   = !all_dead_o && (bottom_pos_o >= land_line_p);
  end

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_off_d    = y_off_q;
    dir_left_d = dir_left_q;
    cnt_d      = cnt_q;
    alive_d    = alive_q;
    hit_ack_d  = 1'b0;
    hit_row_d  = hit_row_q;
    rgb_d      = 12'h000;

    // Hits use the current (pre-step) geometry; lowest matching index wins.
    if ((state_q == IDLE || state_q == MARCH) && hit_i && (hit_m != '0)) begin
      for (int i = rows_p - 1; i >= 0; i--) begin
        if (hit_m[i]) hit_row_d = 3'(i);
      end
      hit_ack_d            = 1'b1;
      alive_d[hit_row_d]   = 1'b0;
    end

    case (state_q)
      IDLE: if (start_i) state_d = MARCH;
      MARCH: begin
        if (all_dead_o)    state_d = DEAD;
        else if (landed_o) state_d = LANDED;
        else if (reverse_i) begin
          dir_left_d = !dir_left_q;
          y_off_d    = y_off_q + 10'(drop_p);
          cnt_d      = '0;
        end else if (frame_i) begin
          if (cnt_q == CW'(frames_per_step_p - 1)) begin
            cnt_d = '0;
            x_d   = dir_left_q ? x_q - 10'(step_p) : x_q + 10'(step_p);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    if (state_q != DEAD) begin
      for (int i = rows_p - 1; i >= 0; i--) begin
        if (pix_m[i]) rgb_d = row_colour(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      x_q        <= left_start_p;
      y_off_q    <= 10'd0;
      dir_left_q <= 1'b0;
      cnt_q      <= '0;
      alive_q    <= '1;
      hit_ack_q  <= 1'b0;
      hit_row_q  <= 3'd0;
      rgb_q      <= 12'h000;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_off_q    <= y_off_d;
      dir_left_q <= dir_left_d;
      cnt_q      <= cnt_d;
      alive_q    <= alive_d;
      hit_ack_q  <= hit_ack_d;
      hit_row_q  <= hit_row_d;
      rgb_q      <= rgb_d;
    end
  end

  assign left_pos_o  = x_q;
  assign right_pos_o = x_q + 10'(enemy_w_p - 1);
  assign hit_ack_o   = hit_ack_q;
  assign hit_row_o   = hit_row_q;
  assign alive_o     = alive_q;
  assign red_o       = rgb_q[11:8];
  assign green_o     = rgb_q[7:4];
  assign blue_o      = rgb_q[3:0];
endmodule

// File: tb/tb_enemy_column_array.sv
// Bench for enemy_column_array with default parameters. Expected kill
// reports go into a queue; a monitor pops one whenever hit_ack_o is seen.
module tb_enemy_column_array;
  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       start_i = 1'b0, frame_i = 1'b0, reverse_i = 1'b0, hit_i = 1'b0;
  logic [9:0] hit_x_i = '0, hit_y_i = '0, pixel_x_i = '0, pixel_y_i = '0;
  logic [9:0] left_pos_o, right_pos_o, bottom_pos_o;
  logic [2:0] shooter_row_o, hit_row_o;
  logic       hit_ack_o, all_dead_o, landed_o;
  logic [3:0] alive_o;
  logic [3:0] red_o, green_o, blue_o;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];

  enemy_column_array dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .frame_i(frame_i),
    .reverse_i(reverse_i), .hit_i(hit_i), .hit_x_i(hit_x_i), .hit_y_i(hit_y_i),
    .pixel_x_i(pixel_x_i), .pixel_y_i(pixel_y_i),
    .left_pos_o(left_pos_o), .right_pos_o(right_pos_o),
    .bottom_pos_o(bottom_pos_o), .shooter_row_o(shooter_row_o),
    .hit_ack_o(hit_ack_o), .hit_row_o(hit_row_o), .alive_o(alive_o),
    .all_dead_o(all_dead_o), .landed_o(landed_o),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every ack must match the next expected row.
  always @(negedge clk_i) begin
    if (!reset_i && hit_ack_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_ack: got row=%0d, required no ack", hit_row_o);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (hit_row_o !== e) begin
          bad++;
          $display("FAIL hit_row: got %0d, required %0d", hit_row_o, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    tick(); tick();
    reset_i = 1'b0;
  endtask

  task automatic do_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  task automatic frames(input int n);
    frame_i = 1'b1;
    repeat (n) tick();
    frame_i = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 5) begin tick(); k++; end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL ack_timeout: pending=%0d, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Shot expected to kill row r.
  task automatic shoot_kill(input logic [9:0] x, input logic [9:0] y, input logic [2:0] r);
    exp_q.push_back(r);
    hit_x_i = x; hit_y_i = y; hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    wait_drain();
  endtask

  // Shot expected to produce no ack.
  task automatic shoot_miss(input string name, input logic [9:0] x, input logic [9:0] y);
    hit_x_i = x; hit_y_i = y; hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    chk(name, {31'd0, hit_ack_o}, 32'd0);
  endtask

  task automatic pix(input string name, input logic [9:0] x, input logic [9:0] y,
                     input logic [11:0] exp);
    pixel_x_i = x; pixel_y_i = y;
    tick();
    chk(name, {20'd0, red_o, green_o, blue_o}, {20'd0, exp});
  endtask

  initial begin
    // 1: reset state and first march step
    do_reset();
    chk("rst_left",  left_pos_o, 9);
    chk("rst_right", right_pos_o, 32);
    chk("rst_alive", alive_o, 4'hF);
    chk("rst_dead",  all_dead_o, 0);
    chk("rst_land",  landed_o, 0);
    chk("rst_ack",   hit_ack_o, 0);
    chk("rst_rgb",   {red_o, green_o, blue_o}, 0);
    chk("rst_shoot", shooter_row_o, 3);
    chk("rst_bot",   bottom_pos_o, 144);
    frames(5);
    chk("idle_frozen", left_pos_o, 9);
    do_start();
    frames(29);
    chk("x_29", left_pos_o, 9);
    frames(1);
    chk("x_30", left_pos_o, 13);
    chk("right_30", right_pos_o, 36);

    // 2: reverse coincident with the stepping frame
    frames(29);
    frame_i = 1'b1; reverse_i = 1'b1; tick(); frame_i = 1'b0; reverse_i = 1'b0;
    chk("rev_x", left_pos_o, 13);
    chk("rev_bot", bottom_pos_o, 152);
    frames(29);
    chk("rev_x29", left_pos_o, 13);
    frames(1);
    chk("rev_x30", left_pos_o, 9);

    // 6 + 3 + 4: pixels, hits, kill sequence
    do_reset();
    do_start();
    pix("pix_tl",   9,  9,  12'hF0F);
    pix("pix_br",   32, 24, 12'hF0F);
    pix("pix_rx",   33, 24, 12'h000);
    pix("pix_ay",   9,  8,  12'h000);
    pix("pix_r1",   20, 50, 12'h0FF);
    pix("pix_r2",   20, 90, 12'hFF0);
    pix("pix_r3",   9,  129, 12'h0F0);
    shoot_kill(15, 55, 1);
    chk("alive_1101", alive_o, 4'b1101);
    shoot_miss("rehit_r1", 15, 55);
    chk("alive_keep", alive_o, 4'b1101);
    shoot_miss("miss_out", 33, 24);
    pix("pix_r1_dead", 20, 50, 12'h000);
    shoot_kill(20, 140, 3);
    chk("shoot_a", shooter_row_o, 2);
    chk("bot_a", bottom_pos_o, 104);
    shoot_kill(20, 100, 2);
    chk("shoot_b", shooter_row_o, 0);
    chk("bot_b", bottom_pos_o, 24);
    pix("pix_r0_alive", 9, 9, 12'hF0F);
    shoot_kill(32, 24, 0);
    chk("alive_0", alive_o, 0);
    chk("all_dead", all_dead_o, 1);
    chk("shoot_none", shooter_row_o, 0);
    chk("bot_none", bottom_pos_o, 0);
    chk("land_dead", landed_o, 0);
    pix("pix_r0_dead", 9, 9, 12'h000);
    frames(30);
    chk("dead_frozen", left_pos_o, 9);

    // 5: landing and mid-state reset
    do_reset();
    do_start();
    reverse_i = 1'b1;
    repeat (36) tick();
    reverse_i = 1'b0;
    chk("bot_36", bottom_pos_o, 432);
    chk("land_36", landed_o, 0);
    reverse_i = 1'b1; tick(); reverse_i = 1'b0;
    chk("bot_37", bottom_pos_o, 440);
    chk("land_37", landed_o, 1);
    frames(30);
    chk("land_x", left_pos_o, 9);
    reverse_i = 1'b1; tick(); reverse_i = 1'b0;
    chk("land_nodrop", bottom_pos_o, 440);
    shoot_miss("land_hit", 9, 305);
    chk("land_alive", alive_o, 4'hF);
    reset_i = 1'b1; tick(); reset_i = 1'b0;
    chk("mid_rst_x", left_pos_o, 9);
    chk("mid_rst_alive", alive_o, 4'hF);
    chk("mid_rst_land", landed_o, 0);
    chk("mid_rst_bot", bottom_pos_o, 144);

    tick(); tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
